// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD event counter that time-multiplexes one digit at a time onto a
// shared BCD-to-seven-segment decoder, with optional leading-zero blanking.
module bcd_scan_counter #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 1000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              en,
   input  logic              clear,
   output logic              W,
   output logic              X,
   output logic              Y,
   output logic              Z,
   output logic [DIGITS-1:0] digit_sel,
   output logic              ovf
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
   logic                   ovf_d;
   logic [PW-1:0]          pre_q, pre_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [3:0]             bcd_q, bcd_c;
   logic [DIGITS-1:0]      sel_c;
   logic [DIGITS-1:0]      lz_c;

   assign W = bcd_q[3];
   assign X = bcd_q[2];
   assign Y = bcd_q[1];
   assign Z = bcd_q[0];

   // Count update: full single-cycle ripple carry; clear beats inc
   always_comb begin : count_next
      logic carry;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      carry = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (en && inc) begin
         carry = 1'b1;
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
               if (cnt_q[i] == 4'd9) begin
                  cnt_d[i] = 4'd0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 4'd1;
                  carry    = 1'b0;
               end
            end
         end
         ovf_d = carry;
      end
   end

   // Prescaler and scan index
   always_comb begin
      pre_d = pre_q + PW'(1);
      idx_d = idx_q;
      if (pre_q == PW'(SCAN_DIV - 1)) begin
         pre_d = '0;
         if (DIGITS > 1) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
         end
      end
   end

   // Digit mux; a digit is leading-zero if it and all higher digits are 0 (digit 0 never is)
   always_comb begin : display_next
      logic nz;
      logic blank;
      nz    = 1'b0;
      blank = 1'b0;
      lz_c  = '0;
      bcd_c = 4'd0;
      sel_c = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         nz      = nz | (cnt_q[i] != 4'd0);
         lz_c[i] = !nz && (i != 0);
      end
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IW'(i)) begin
            bcd_c    = cnt_q[i];
            sel_c[i] = 1'b1;
            blank    = lz_c[i];
         end
      end
      if (BLANK_LZ && blank) begin
         bcd_c = 4'd0;
         sel_c = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         ovf       <= 1'b0;
         pre_q     <= '0;
         idx_q     <= '0;
         bcd_q     <= 4'd0;
         digit_sel <= DIGITS'(1);
      end else begin
         cnt_q     <= cnt_d;
         ovf       <= ovf_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         bcd_q     <= bcd_c;
         digit_sel <= sel_c;
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: one instance without and one with leading-zero
// blanking, driven by the same stimulus, DIGITS=4 and SCAN_DIV=4.
module tb_bcd_scan_counter;

   logic       clk;
   logic       reset;
   logic       inc;
   logic       en;
   logic       clear;
   logic       wa, xa, ya, za, ovf_a;
   logic       wb, xb, yb, zb, ovf_b;
   logic [3:0] sel_a, sel_b;
   logic [3:0] bcd_a, bcd_b;
   int         n_assert;
   int         n_fail;

   assign bcd_a = {wa, xa, ya, za};
   assign bcd_b = {wb, xb, yb, zb};

   bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_a (
      .clk(clk), .reset(reset), .inc(inc), .en(en), .clear(clear),
      .W(wa), .X(xa), .Y(ya), .Z(za), .digit_sel(sel_a), .ovf(ovf_a)
   );

   bcd_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_b (
      .clk(clk), .reset(reset), .inc(inc), .en(en), .clear(clear),
      .W(wb), .X(xb), .Y(yb), .Z(zb), .digit_sel(sel_b), .ovf(ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] onehot(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   initial begin
      int   idx;
      logic saw_ovf;
      n_assert = 0;
      n_fail   = 0;
      reset = 1'b1; inc = 1'b1; en = 1'b1; clear = 1'b0;

      // Reset held 3 cycles with inc asserted
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_bcd", bcd_a, 4'h0);
         chk("rst_sel", sel_a, 4'b0001);
         chk("rst_ovf", 4'(ovf_a), 4'h0);
         chk("rst_sel_b", sel_b, 4'b0001);
      end

      // Carry: 10 incs -> 0010, then one full scan rotation
      reset = 1'b0;
      repeat (10) tick();
      inc = 1'b0;
      repeat (6) tick();
      for (int k = 17; k <= 32; k++) begin
         tick();
         idx = ((k - 1) / 4) % 4;
         chk("carry_sel", sel_a, onehot(idx));
         chk("carry_bcd", bcd_a, (idx == 1) ? 4'h1 : 4'h0);
         chk("carry_sel_b", sel_b, (idx < 2) ? onehot(idx) : 4'b0000);
      end

      // Wrap: 9999 incs then one more
      reset = 1'b1; tick(); reset = 1'b0;
      inc = 1'b1;
      saw_ovf = 1'b0;
      for (int k = 1; k <= 9999; k++) begin
         tick();
         saw_ovf = saw_ovf | ovf_a;
      end
      chk("wrap_no_early_ovf", 4'(saw_ovf), 4'h0);
      chk("wrap_9998_d3", bcd_a, 4'h9);
      tick();
      inc = 1'b0;
      chk("wrap_ovf", 4'(ovf_a), 4'h1);
      chk("wrap_ovf_b", 4'(ovf_b), 4'h1);
      chk("wrap_9999_d3", bcd_a, 4'h9);
      chk("wrap_9999_sel", sel_a, 4'b1000);
      tick();
      chk("wrap_ovf_drop", 4'(ovf_a), 4'h0);
      chk("wrap_zero_d0", bcd_a, 4'h0);
      chk("wrap_zero_sel", sel_a, 4'b0001);

      // Priority: count 0123, clear with inc, then inc with en low
      reset = 1'b1; tick(); reset = 1'b0;
      inc = 1'b1;
      repeat (123) tick();
      clear = 1'b1;
      tick();
      chk("pri_0123_d2", bcd_a, 4'h1);
      chk("pri_0123_sel", sel_a, 4'b0100);
      clear = 1'b0; en = 1'b0;
      tick();
      chk("pri_clear_ovf", 4'(ovf_a), 4'h0);
      for (int k = 126; k <= 140; k++) begin
         tick();
         if (k == 129 || k == 133 || k == 137) begin
            idx = ((k - 1) / 4) % 4;
            chk("pri_sel", sel_a, onehot(idx));
            chk("pri_bcd", bcd_a, 4'h0);
            chk("pri_sel_b", sel_b, (idx == 0) ? 4'b0001 : 4'b0000);
         end
      end
      inc = 1'b0; en = 1'b1;

      // Blanking: count 0042, then cleared to 0000
      reset = 1'b1; tick(); reset = 1'b0;
      inc = 1'b1;
      repeat (42) tick();
      inc = 1'b0;
      repeat (6) tick();
      for (int k = 49; k <= 64; k++) begin
         tick();
         idx = ((k - 1) / 4) % 4;
         chk("blank_sel_b", sel_b, (idx < 2) ? onehot(idx) : 4'b0000);
         chk("blank_bcd_b", bcd_b, (idx == 0) ? 4'h2 : (idx == 1) ? 4'h4 : 4'h0);
         chk("blank_sel_a", sel_a, onehot(idx));
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int k = 66; k <= 81; k++) begin
         tick();
         idx = ((k - 1) / 4) % 4;
         chk("zero_sel_b", sel_b, (idx == 0) ? 4'b0001 : 4'b0000);
         chk("zero_bcd_b", bcd_b, 4'h0);
      end

      // Reset mid-operation at prescaler=2, index=2 with count 5
      reset = 1'b1; tick(); reset = 1'b0;
      inc = 1'b1;
      repeat (5) tick();
      inc = 1'b0;
      repeat (5) tick();
      chk("mid_pre_sel", sel_a, 4'b0100);
      reset = 1'b1; inc = 1'b1;
      tick();
      chk("mid_rst_sel", sel_a, 4'b0001);
      chk("mid_rst_bcd", bcd_a, 4'h0);
      chk("mid_rst_ovf", 4'(ovf_a), 4'h0);
      reset = 1'b0; inc = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("mid_sel", sel_a, (k <= 4) ? 4'b0001 : 4'b0010);
         chk("mid_bcd", bcd_a, 4'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
